// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if
//   Target-duty request channel between control logic and the ramp sequencer.
//   A request moves on the rising clock edge where I_valid and O_ready are both high.
// Signals
//   I_valid   1  target-duty request valid (driven by the master)
//   I_target  8  requested duty, 0..255 (driven by the master)
//   O_ready   1  sequencer can accept a request this cycle (driven by the slave)
// Modports
//   master : control logic side
//   slave  : pwm_ramp_sequencer side
interface pwm_ramp_sequencer_if;
  logic       I_valid;
  logic [7:0] I_target;
  logic       O_ready;

  modport master (
    output I_valid,
    output I_target,
    input  O_ready
  );

  modport slave (
    input  I_valid,
    input  I_target,
    output O_ready
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
//   Duty-cycle sequencer in front of the 8-bit PWM generator. It accepts a target
//   duty over the request channel, slews O_duty toward it by STEP once every
//   TICK_CYCLES clocks, holds it there, and gates the generator enable.
//   Optional feature macro: PWM_RAMP_SOFTSTOP_EN. When defined, dropping I_en
//   while running ramps the duty down to 0 before the generator is disabled.
//   When undefined, dropping I_en disables the generator on the next edge.
// Parameters
//   TICK_CYCLES  clocks per ramp step (>= 1)
//   STEP         duty change per tick, 1..100
//   DUTY_MAX     upper duty limit; larger targets are clamped to it
// Ports
//   I_clk     in   1   system clock
//   I_rst     in   1   synchronous reset, active high
//   I_en      in   1   channel enable, active high
//   req       if       request channel (slave modport): I_valid, I_target, O_ready
//   O_duty    out  8   duty to the PWM generator, never above DUTY_MAX
//   O_en      out  1   enable to the PWM generator
//   O_busy    out  1   high while ramping or soft-stopping
//   O_done    out  1   one-cycle pulse when O_duty reaches the accepted target
module pwm_ramp_sequencer #(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter logic [7:0]  STEP        = 8'd1,
  parameter logic [7:0]  DUTY_MAX    = 8'd100
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_en,
  pwm_ramp_sequencer_if.slave    req,
  output logic [7:0]             O_duty,
  output logic                   O_en,
  output logic                   O_busy,
  output logic                   O_done
);

  localparam int unsigned    CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

`ifdef PWM_RAMP_SOFTSTOP_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       duty_q, duty_d;
  logic [7:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ready;
  logic             accept;
  logic             tick_done;
  logic [7:0]       target_clamped;
  logic [7:0]       ramp_duty;
`ifdef PWM_RAMP_SOFTSTOP_EN
  logic [7:0]       stop_duty;
`endif

  // Moves cur one STEP toward tgt. The distance is checked before the add or
  // subtract, so the result lands exactly on tgt instead of overshooting it,
  // and an 8-bit wrap can never happen.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] diff;
    logic [7:0] res;
    if (cur < tgt) begin
      diff = tgt - cur;
      res  = (diff <= STEP) ? tgt : (cur + STEP);
    end else begin
      diff = cur - tgt;
      res  = (diff <= STEP) ? tgt : (cur - STEP);
    end
    return res;
  endfunction

  // Requests are taken only while the channel is enabled and the sequencer is
  // settled (IDLE or HOLD). Because I_en is part of ready, a request that arrives
  // on the same cycle I_en drops is never accepted.
  assign ready          = I_en & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign req.O_ready    = ready;
  assign accept         = req.I_valid & ready;
  assign target_clamped = (req.I_target > DUTY_MAX) ? DUTY_MAX : req.I_target;
  assign tick_done      = (cnt_q == CNT_LAST);
  assign ramp_duty      = step_toward(duty_q, target_q);
`ifdef PWM_RAMP_SOFTSTOP_EN
  assign stop_duty      = step_toward(duty_q, 8'd0);
`endif

  // Next-state and next-output logic. Every output is computed here as the
  // value it will hold after the next edge, so the register block below can
  // just load them and all outputs stay registered.
  // An accepted target equal to the present duty goes straight to HOLD with a
  // done pulse; any other target starts a ramp with a freshly cleared counter.
  // Losing I_en while running either parks everything at once or, with the
  // soft-stop build, hands over to STOP which ramps the duty down to 0 first.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        duty_d = 8'd0;
        en_d   = 1'b0;
        cnt_d  = '0;
        if (accept) begin
          target_d = target_clamped;
          en_d     = 1'b1;
          if (target_clamped == duty_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end

      ST_RAMP, ST_HOLD: begin
        if (!I_en) begin
          cnt_d = '0;
`ifdef PWM_RAMP_SOFTSTOP_EN
          if (duty_q == 8'd0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            state_d = ST_STOP;
            en_d    = 1'b1;
          end
`else
          state_d = ST_IDLE;
          duty_d  = 8'd0;
          en_d    = 1'b0;
`endif
        end else if (state_q == ST_HOLD) begin
          en_d = 1'b1;
          if (accept) begin
            target_d = target_clamped;
            cnt_d    = '0;
            if (target_clamped == duty_q) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RAMP;
            end
          end
        end else begin
          en_d = 1'b1;
          if (tick_done) begin
            cnt_d  = '0;
            duty_d = ramp_duty;
            if (ramp_duty == target_q) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef PWM_RAMP_SOFTSTOP_EN
      ST_STOP: begin
        en_d = 1'b1;
        if (tick_done) begin
          cnt_d  = '0;
          duty_d = stop_duty;
          if (stop_duty == 8'd0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d  = ST_IDLE;
        duty_d   = 8'd0;
        en_d     = 1'b0;
        cnt_d    = '0;
      end
    endcase

`ifdef PWM_RAMP_SOFTSTOP_EN
    busy_d = (state_d == ST_RAMP) | (state_d == ST_STOP);
`else
    busy_d = (state_d == ST_RAMP);
`endif
  end

  // State and output registers. Reset is synchronous and may arrive at any
  // time, including in the middle of a ramp; it returns the block to a quiet
  // IDLE with the latched target and tick counter cleared.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= ST_IDLE;
      duty_q   <= 8'd0;
      target_q <= 8'd0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign O_duty = duty_q;
  assign O_en   = en_q;
  assign O_busy = busy_q;
  assign O_done = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer
//   Directed self-checking bench for pwm_ramp_sequencer with TICK_CYCLES=4,
//   STEP=10, DUTY_MAX=100. Expected values are written out by hand; the
//   soft-stop expectations follow PWM_RAMP_SOFTSTOP_EN when it is defined.
module tb_pwm_ramp_sequencer;

  logic       I_clk;
  logic       I_rst;
  logic       I_en;
  logic [7:0] O_duty;
  logic       O_en;
  logic       O_busy;
  logic       O_done;

  int checkCount;
  int errorCount;

  pwm_ramp_sequencer_if req_if ();

  pwm_ramp_sequencer #(
    .TICK_CYCLES (4),
    .STEP        (8'd10),
    .DUTY_MAX    (8'd100)
  ) dut (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_en   (I_en),
    .req    (req_if),
    .O_duty (O_duty),
    .O_en   (O_en),
    .O_busy (O_busy),
    .O_done (O_done)
  );

  // Free-running 10-time-unit clock.
  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  // Advances n rising edges and parks 1 unit after the last, where outputs
  // are stable and new inputs can be driven for the following edge.
  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge I_clk);
      #1;
    end
  endtask

  // Drives all DUT inputs at once.
  task automatic applyStimulus(input logic rst, input logic en, input logic valid,
                               input logic [7:0] target);
    I_rst           = rst;
    I_en            = en;
    req_if.I_valid  = valid;
    req_if.I_target = target;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One ramp tick: three edges with the duty held at prev and no done pulse,
  // then the edge where the duty moves to nxt and done is lastDone.
  task automatic rampStep(input logic [7:0] prev, input logic [7:0] nxt,
                          input logic lastDone, input string tag);
    for (int i = 0; i < 3; i++) begin
      stepClk(1);
      checkOutput({tag, "_hold"}, O_duty, prev);
      checkOutput({tag, "_nodone"}, O_done, 1'b0);
    end
    stepClk(1);
    checkOutput({tag, "_duty"}, O_duty, nxt);
    checkOutput({tag, "_done"}, O_done, lastDone);
  endtask

  // Expectations after I_en drops in HOLD at 35 (valid may be held high).
  task automatic checkDisable(input string tag, input logic validHeld);
    applyStimulus(1'b0, 1'b0, validHeld, 8'd80);
    #1;
    checkOutput({tag, "_ready_now"}, req_if.O_ready, 1'b0);
    stepClk(1);
`ifdef PWM_RAMP_SOFTSTOP_EN
    checkOutput({tag, "_stop_busy"}, O_busy, 1'b1);
    checkOutput({tag, "_stop_en"}, O_en, 1'b1);
    checkOutput({tag, "_stop_duty"}, O_duty, 8'd35);
    checkOutput({tag, "_stop_ready"}, req_if.O_ready, 1'b0);
    rampStep(8'd35, 8'd25, 1'b0, {tag, "_s25"});
    rampStep(8'd25, 8'd15, 1'b0, {tag, "_s15"});
    rampStep(8'd15, 8'd5, 1'b0, {tag, "_s5"});
    rampStep(8'd5, 8'd0, 1'b0, {tag, "_s0"});
    checkOutput({tag, "_idle_en"}, O_en, 1'b0);
    checkOutput({tag, "_idle_busy"}, O_busy, 1'b0);
`else
    checkOutput({tag, "_off_duty"}, O_duty, 8'd0);
    checkOutput({tag, "_off_en"}, O_en, 1'b0);
    checkOutput({tag, "_off_busy"}, O_busy, 1'b0);
    checkOutput({tag, "_off_done"}, O_done, 1'b0);
`endif
    stepClk(2);
    checkOutput({tag, "_stay_duty"}, O_duty, 8'd0);
    checkOutput({tag, "_stay_en"}, O_en, 1'b0);
    checkOutput({tag, "_stay_done"}, O_done, 1'b0);
  endtask

  // Accepts a target from IDLE or HOLD and releases I_valid after the edge.
  task automatic acceptTarget(input logic [7:0] target);
    applyStimulus(1'b0, 1'b1, 1'b1, target);
    stepClk(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    logic [7:0] prevDuty;
    logic [7:0] nextDuty;
    checkCount = 0;
    errorCount = 0;

    // Reset held for two edges with I_en high.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    stepClk(2);
    checkOutput("rst_duty", O_duty, 8'd0);
    checkOutput("rst_en", O_en, 1'b0);
    checkOutput("rst_busy", O_busy, 1'b0);
    checkOutput("rst_done", O_done, 1'b0);
    checkOutput("rst_ready", req_if.O_ready, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepClk(1);

    // Soft start from IDLE to 35.
    acceptTarget(8'd35);
    checkOutput("up_busy", O_busy, 1'b1);
    checkOutput("up_en", O_en, 1'b1);
    checkOutput("up_ready", req_if.O_ready, 1'b0);
    checkOutput("up_duty0", O_duty, 8'd0);
    rampStep(8'd0, 8'd10, 1'b0, "up10");
    rampStep(8'd10, 8'd20, 1'b0, "up20");
    rampStep(8'd20, 8'd30, 1'b0, "up30");
    rampStep(8'd30, 8'd35, 1'b1, "up35");
    checkOutput("hold35_busy", O_busy, 1'b0);
    checkOutput("hold35_ready", req_if.O_ready, 1'b1);
    stepClk(1);
    checkOutput("hold35_done", O_done, 1'b0);
    checkOutput("hold35_duty", O_duty, 8'd35);
    checkOutput("hold35_en", O_en, 1'b1);

    // Slew down from 35 to 5.
    acceptTarget(8'd5);
    checkOutput("dn_busy", O_busy, 1'b1);
    rampStep(8'd35, 8'd25, 1'b0, "dn25");
    rampStep(8'd25, 8'd15, 1'b0, "dn15");
    rampStep(8'd15, 8'd5, 1'b1, "dn5");

    // Same target as the present duty: done next cycle, no ramp.
    acceptTarget(8'd5);
    checkOutput("same_done", O_done, 1'b1);
    checkOutput("same_busy", O_busy, 1'b0);
    checkOutput("same_duty", O_duty, 8'd5);
    stepClk(1);
    checkOutput("same_done_end", O_done, 1'b0);
    checkOutput("same_ready", req_if.O_ready, 1'b1);

    // Oversized target clamps at 100.
    acceptTarget(8'd200);
    prevDuty = 8'd5;
    while (prevDuty != 8'd100) begin
      nextDuty = (prevDuty > 8'd90) ? 8'd100 : prevDuty + 8'd10;
      rampStep(prevDuty, nextDuty, (nextDuty == 8'd100), "clamp");
      prevDuty = nextDuty;
    end
    stepClk(5);
    checkOutput("clamp_duty", O_duty, 8'd100);
    checkOutput("clamp_busy", O_busy, 1'b0);
    checkOutput("clamp_done", O_done, 1'b0);

    // Down to 35 with I_valid held high (target 0) during the ramp.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd35);
    stepClk(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    checkOutput("vh_ready", req_if.O_ready, 1'b0);
    prevDuty = 8'd100;
    while (prevDuty != 8'd40) begin
      rampStep(prevDuty, prevDuty - 8'd10, 1'b0, "vh");
      checkOutput("vh_ready_ramp", req_if.O_ready, 1'b0);
      prevDuty = prevDuty - 8'd10;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    rampStep(8'd40, 8'd35, 1'b1, "vh35");
    for (int i = 0; i < 4; i++) begin
      stepClk(1);
      checkOutput("vh_hold_duty", O_duty, 8'd35);
      checkOutput("vh_hold_done", O_done, 1'b0);
    end

    // Drop I_en while holding at 35.
    checkDisable("dis", 1'b0);

    // Ramp back up to 35, then drop I_en together with a new request.
    acceptTarget(8'd35);
    rampStep(8'd0, 8'd10, 1'b0, "re10");
    rampStep(8'd10, 8'd20, 1'b0, "re20");
    rampStep(8'd20, 8'd30, 1'b0, "re30");
    rampStep(8'd30, 8'd35, 1'b1, "re35");
    stepClk(1);
    checkDisable("coin", 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    stepClk(1);

    // Reset in the middle of a ramp, then confirm a clean restart.
    acceptTarget(8'd50);
    rampStep(8'd0, 8'd10, 1'b0, "mr10");
    stepClk(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    stepClk(1);
    checkOutput("mrst_duty", O_duty, 8'd0);
    checkOutput("mrst_en", O_en, 1'b0);
    checkOutput("mrst_busy", O_busy, 1'b0);
    checkOutput("mrst_done", O_done, 1'b0);
    checkOutput("mrst_ready", req_if.O_ready, 1'b1);
    stepClk(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    acceptTarget(8'd20);
    rampStep(8'd0, 8'd10, 1'b0, "post10");
    rampStep(8'd10, 8'd20, 1'b1, "post20");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
